// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave register file.
//   DATA_W / STRB_W : data bus and byte-strobe widths
//   RESP_*          : AXI response encodings
//   wr_state_e      : write-channel controller states
//   merge_strb      : byte-lane merge of new data into an old word
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_HOLD = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    function automatic logic [DATA_W-1:0] merge_strb(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_data;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// Write-channel controller: accepts AW and W independently, commits the
// write on the edge where both are available, and holds the B response
// until the master takes it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// WR_IDLE | nothing held, AW and W both acceptable
// WR_HOLD | exactly one of AW / W held, waiting for the other
// WR_RESP | write committed (or rejected), bvalid high until bready
//
// Ports:
//   aclk, areset               clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*          AXI-Lite write address / data / response
//   reg_we                     one-cycle register write strobe (valid addr)
//   reg_idx                    register index for reg_we
//   reg_wdata, reg_wstrb       data and byte strobes for reg_we
module axi_lite_wr_ctrl
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_W      = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [STRB_W-1:0]     s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic                  reg_we,
    output logic [IDX_W-1:0]      reg_idx,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic [STRB_W-1:0]     reg_wstrb
);

    wr_state_e state, state_nxt;

    logic                  aw_held, aw_held_nxt;
    logic                  w_held, w_held_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [STRB_W-1:0]     strb_q;
    logic [1:0]            bresp_q;

    logic                  aw_hs, w_hs;
    logic                  fire;
    logic                  addr_ok;
    logic [ADDR_WIDTH-1:0] cur_addr;

    assign s_awready = !aw_held && (state != WR_RESP);
    assign s_wready  = !w_held  && (state != WR_RESP);
    assign s_bvalid  = (state == WR_RESP);
    assign s_bresp   = bresp_q;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid  && s_wready;

    // A channel arriving this cycle bypasses its holding register so a
    // same-cycle AW+W (or the second arrival) commits on this very edge.
    assign cur_addr  = aw_hs ? s_awaddr : addr_q;
    assign reg_wdata = w_hs  ? s_wdata  : data_q;
    assign reg_wstrb = w_hs  ? s_wstrb  : strb_q;
    assign reg_idx   = cur_addr[IDX_W+1:2];
    assign addr_ok   = ((cur_addr >> (IDX_W + 2)) == '0);
    assign reg_we    = fire && addr_ok;

    always_comb begin
        state_nxt   = state;
        aw_held_nxt = aw_held || aw_hs;
        w_held_nxt  = w_held  || w_hs;
        fire        = 1'b0;
        case (state)
            WR_IDLE, WR_HOLD: begin
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    fire      = 1'b1;
                    state_nxt = WR_RESP;
                end else if (aw_held_nxt || w_held_nxt) begin
                    state_nxt = WR_HOLD;
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    state_nxt   = WR_IDLE;
                    aw_held_nxt = 1'b0;
                    w_held_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt   = WR_IDLE;
                aw_held_nxt = 1'b0;
                w_held_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= WR_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state   <= state_nxt;
            aw_held <= aw_held_nxt;
            w_held  <= w_held_nxt;
            if (aw_hs) begin
                addr_q <= s_awaddr;
            end
            if (w_hs) begin
                data_q <= s_wdata;
                strb_q <= s_wstrb;
            end
            if (fire) begin
                bresp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave holding NUM_REGS 32-bit registers with byte-strobe
// writes. Write and read channels are independent; a read and a write to
// the same register on the same edge returns the pre-write value.
//
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*    write address / data / response channels
//   s_ar*, s_r*          read address / data channels
// Out-of-range addresses (any bit above the register window set) answer
// SLVERR; reads of them return zero and writes change nothing.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [STRB_W-1:0]     s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              reg_we;
    logic [IDX_W-1:0]  reg_idx;
    logic [DATA_W-1:0] reg_wdata;
    logic [STRB_W-1:0] reg_wstrb;

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              ar_hs;
    logic              ar_ok;
    logic [IDX_W-1:0]  ar_idx;

    axi_lite_wr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W)
    ) u_wr_ctrl (
        .aclk      (aclk),
        .areset    (areset),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .reg_we    (reg_we),
        .reg_idx   (reg_idx),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[reg_idx] <= merge_strb(regs[reg_idx], reg_wdata, reg_wstrb);
        end
    end

    assign s_arready = !rvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    assign ar_hs  = s_arvalid && !rvalid_q;
    assign ar_ok  = ((s_araddr >> (IDX_W + 2)) == '0);
    assign ar_idx = s_araddr[IDX_W+1:2];

    // rdata samples the array with a non-blocking read, so a write landing
    // on the same edge is not visible in this response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_ok ? regs[ar_idx] : '0;
            rresp_q  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
module tb_axi_lite_slave_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int         NREG   = 16;
    localparam logic [31:0] WIN   = 32'd64;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    axi_lite_slave_regs #(.ADDR_WIDTH(32), .NUM_REGS(NREG)) dut (
        .aclk(aclk), .areset(areset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents plus outstanding channel queues.
    logic [31:0] m_regs [NREG];
    logic [31:0] q_awaddr [$];
    logic [31:0] q_wdata  [$];
    logic [3:0]  q_wstrb  [$];
    logic [1:0]  q_b      [$];
    logic [31:0] q_rdata  [$];
    logic [1:0]  q_rresp  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Called at every falling edge: checks outputs against the model, then
    // advances the model by the handshakes that the next rising edge takes.
    task automatic mon_step();
        logic [31:0] a, d, w;
        logic [3:0]  s;
        if (areset) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            q_awaddr.delete(); q_wdata.delete(); q_wstrb.delete();
            q_b.delete(); q_rdata.delete(); q_rresp.delete();
            return;
        end
        chk("bvalid", {31'd0, s_bvalid}, {31'd0, q_b.size() != 0});
        if (q_b.size() != 0) chk("bresp", {30'd0, s_bresp}, {30'd0, q_b[0]});
        chk("rvalid", {31'd0, s_rvalid}, {31'd0, q_rdata.size() != 0});
        if (q_rdata.size() != 0) begin
            chk("rdata", s_rdata, q_rdata[0]);
            chk("rresp", {30'd0, s_rresp}, {30'd0, q_rresp[0]});
        end
        chk("awready", {31'd0, s_awready}, {31'd0, q_awaddr.size() == 0 && q_b.size() == 0});
        chk("wready",  {31'd0, s_wready},  {31'd0, q_wdata.size() == 0 && q_b.size() == 0});
        chk("arready", {31'd0, s_arready}, {31'd0, q_rdata.size() == 0});

        if (s_bvalid && s_bready && q_b.size() != 0) void'(q_b.pop_front());
        if (s_rvalid && s_rready && q_rdata.size() != 0) begin
            void'(q_rdata.pop_front());
            void'(q_rresp.pop_front());
        end
        // Read is evaluated before any write on the same edge.
        if (s_arvalid && s_arready) begin
            a = s_araddr;
            if (a < WIN) begin
                q_rdata.push_back(m_regs[a[5:2]]);
                q_rresp.push_back(OKAY);
            end else begin
                q_rdata.push_back('0);
                q_rresp.push_back(SLVERR);
            end
        end
        if (s_awvalid && s_awready) q_awaddr.push_back(s_awaddr);
        if (s_wvalid && s_wready) begin
            q_wdata.push_back(s_wdata);
            q_wstrb.push_back(s_wstrb);
        end
        if (q_awaddr.size() != 0 && q_wdata.size() != 0) begin
            a = q_awaddr.pop_front();
            d = q_wdata.pop_front();
            s = q_wstrb.pop_front();
            if (a < WIN) begin
                w = m_regs[a[5:2]];
                for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
                m_regs[a[5:2]] = w;
                q_b.push_back(OKAY);
            end else begin
                q_b.push_back(SLVERR);
            end
        end
    endtask

    // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdly,
                            output logic [1:0] resp, output int lat);
        bit aw_done, w_done;
        int aw_wait, w_wait;
        aw_done = 0;
        w_done  = 0;
        aw_wait = (lead > 0) ? lead : 0;
        w_wait  = (lead < 0) ? -lead : 0;
        resp = 2'b11;
        s_awaddr = a;
        s_wdata  = d;
        s_wstrb  = s;
        for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
            s_awvalid = !aw_done && (c >= aw_wait);
            s_wvalid  = !w_done  && (c >= w_wait);
            @(negedge aclk);
            if (s_awvalid && s_awready) aw_done = 1;
            if (s_wvalid && s_wready) w_done = 1;
            @(posedge aclk); #1;
        end
        s_awvalid = 0;
        s_wvalid  = 0;
        if (!(aw_done && w_done)) tmo("write_handshake");
        for (lat = 0; lat < 20 && !s_bvalid; lat++) begin
            @(posedge aclk); #1;
        end
        if (!s_bvalid) begin
            tmo("write_bvalid");
            return;
        end
        resp = s_bresp;
        repeat (bdly) begin
            @(posedge aclk); #1;
            chk("bhold_bvalid",  {31'd0, s_bvalid},  32'd1);
            chk("bhold_bresp",   {30'd0, s_bresp},   {30'd0, resp});
            chk("bhold_awready", {31'd0, s_awready}, 32'd0);
            chk("bhold_wready",  {31'd0, s_wready},  32'd0);
        end
        s_bready = 1;
        @(posedge aclk); #1;
        s_bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int rdly,
                           output logic [31:0] d, output logic [1:0] r);
        bit done;
        done = 0;
        d = '0;
        r = 2'b11;
        s_araddr  = a;
        s_arvalid = 1;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge aclk);
            done = s_arready;
            @(posedge aclk); #1;
        end
        s_arvalid = 0;
        if (!done) tmo("read_handshake");
        for (int c = 0; c < 20 && !s_rvalid; c++) begin
            @(posedge aclk); #1;
        end
        if (!s_rvalid) begin
            tmo("read_rvalid");
            return;
        end
        d = s_rdata;
        r = s_rresp;
        repeat (rdly) begin
            @(posedge aclk); #1;
        end
        s_rready = 1;
        @(posedge aclk); #1;
        s_rready = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r, wr;
        int          lat;

        fork
            forever begin
                @(negedge aclk);
                mon_step();
            end
        join_none

        repeat (3) @(posedge aclk);
        #1 areset = 0;
        @(posedge aclk); #1;

        do_read(32'h00, 0, d, r);
        chk("rst_rd00_data", d, 32'h0);
        chk("rst_rd00_resp", {30'd0, r}, {30'd0, OKAY});
        do_read(32'h3C, 1, d, r);
        chk("rst_rd3c_data", d, 32'h0);
        chk("rst_rd3c_resp", {30'd0, r}, {30'd0, OKAY});

        do_write(32'h04, 32'h11111111, 4'hF, 0, 0, wr, lat);
        chk("wr04_resp", {30'd0, wr}, {30'd0, OKAY});
        chk("wr04_lat", lat, 32'd0);
        do_read(32'h04, 0, d, r);
        chk("rd04_data", d, 32'h11111111);

        do_write(32'h08, 32'h22222222, 4'hF, 2, 0, wr, lat);
        chk("wr08_resp", {30'd0, wr}, {30'd0, OKAY});
        chk("wr08_lat", lat, 32'd0);
        do_read(32'h08, 0, d, r);
        chk("rd08_data", d, 32'h22222222);

        do_write(32'h20, 32'h12345678, 4'b1111, 0, 0, wr, lat);
        do_write(32'h20, ($urandom & 32'hFFFFFF00) | 32'hAA, 4'b0001, -1, 0, wr, lat);
        do_read(32'h20, 0, d, r);
        chk("rd20_strb0001", d, 32'h123456AA);
        do_write(32'h20, ($urandom & 32'hFF00FFFF) | 32'h00BB0000, 4'b0100, 1, 0, wr, lat);
        do_read(32'h21, 0, d, r);
        chk("rd20_strb0100", d, 32'h12BB56AA);
        do_write(32'h20, ($urandom & 32'h00FF00FF) | 32'hDD00CC00, 4'b1010, 0, 1, wr, lat);
        do_read(32'h23, 0, d, r);
        chk("rd20_strb1010", d, 32'hDDBBCCAA);

        do_write(32'h24, 32'h5A5A5A5A, 4'hF, 0, 0, wr, lat);
        fork
            begin
                logic [1:0] wr2;
                int lat2;
                do_write(32'h24, 32'hCCCCCCCC, 4'hF, 0, 0, wr2, lat2);
            end
            begin
                logic [31:0] d2;
                logic [1:0]  r2;
                do_read(32'h24, 0, d2, r2);
                chk("rd24_collide_old", d2, 32'h5A5A5A5A);
            end
        join
        do_read(32'h24, 0, d, r);
        chk("rd24_after", d, 32'hCCCCCCCC);

        do_write(32'h28, 32'h0F0F0F0F, 4'hF, -1, 5, wr, lat);
        chk("wr28_resp", {30'd0, wr}, {30'd0, OKAY});

        do_write(32'h40, 32'hDEADBEEF, 4'hF, 0, 0, wr, lat);
        chk("wr40_resp", {30'd0, wr}, {30'd0, SLVERR});
        do_read(32'h40, 0, d, r);
        chk("rd40_data", d, 32'h0);
        chk("rd40_resp", {30'd0, r}, {30'd0, SLVERR});
        do_read(32'h00, 0, d, r);
        chk("rd00_untouched", d, 32'h0);
        do_write(32'h0000_0014, 32'h0, 4'h0, 0, 0, wr, lat);
        chk("wr14_nostrb_resp", {30'd0, wr}, {30'd0, OKAY});

        fork
            begin
                logic [1:0] wr3;
                int lat3;
                for (int k = 0; k < 150; k++) begin
                    logic [31:0] ra;
                    ra = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h40) : 32'($urandom_range(0, 63));
                    do_write(ra, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                             int'($urandom_range(0, 3)), wr3, lat3);
                end
            end
            begin
                logic [31:0] d3;
                logic [1:0]  r3;
                for (int k = 0; k < 150; k++) begin
                    logic [31:0] ra;
                    ra = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h40) : 32'($urandom_range(0, 63));
                    do_read(ra, int'($urandom_range(0, 3)), d3, r3);
                    repeat ($urandom_range(0, 2)) @(posedge aclk);
                    #1;
                end
            end
        join
        @(posedge aclk); #1;

        s_awaddr  = 32'h10;
        s_awvalid = 1;
        @(posedge aclk); #1;
        s_awvalid = 0;
        areset = 1;
        @(posedge aclk); #1;
        areset = 0;
        repeat (5) begin
            @(posedge aclk); #1;
            chk("rst_no_bvalid", {31'd0, s_bvalid}, 32'd0);
        end
        for (int i = 0; i < NREG; i++) begin
            do_read(32'(i * 4), 0, d, r);
            chk("rst_reg_zero", d, 32'h0);
        end

        repeat (3) @(posedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
